mode_sequencer: RTL and testbench

Top-level mode controller for the digital-clock design. Cycles the one-hot `MODE` bus (clock → time set → alarm set → stopwatch) on a mode-button pulse and forwards the synchronized number/cursor button pulses only to the active editing submodule. Issues single-cycle commit strobes when time-set or alarm-set mode is left after an edit. Optionally returns to clock mode after a period of inactivity.

---
 rtl/clock_pkg.sv | 31 +++
 rtl/idle_timer.sv | 25 ++
 rtl/mode_sequencer.sv | 73 +++++++
 tb/tb_mode_sequencer.sv | 116 +++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: mode encodings, button bit indices and mode helpers shared by the digital-clock blocks.
package clock_pkg;

    localparam logic [3:0] MODE_CLOCK     = 4'b1000;
    localparam logic [3:0] MODE_TIME_SET  = 4'b0001;
    localparam logic [3:0] MODE_ALARM_SET = 4'b0010;
    localparam logic [3:0] MODE_STOPWATCH = 4'b0100;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_RIGHT = 2;
    localparam int BTN_LEFT  = 3;

    typedef enum logic [3:0] {
        ST_CLOCK     = MODE_CLOCK,
        ST_TIME_SET  = MODE_TIME_SET,
        ST_ALARM_SET = MODE_ALARM_SET,
        ST_STOPWATCH = MODE_STOPWATCH
    } mode_t;

    function automatic mode_t next_mode(input mode_t m);
        return (m == ST_CLOCK)     ? ST_TIME_SET  :
               (m == ST_TIME_SET)  ? ST_ALARM_SET :
               (m == ST_ALARM_SET) ? ST_STOPWATCH : ST_CLOCK;
    endfunction

    function automatic logic is_edit(input mode_t m);
        return (m == ST_TIME_SET) || (m == ST_ALARM_SET);
    endfunction

endpackage

// File: rtl/idle_timer.sv
// idle_timer: saturating 8-bit tick counter that pulses expire on the TIMEOUT_TICKS-th tick since clear.
module idle_timer #(
    parameter int TIMEOUT_TICKS = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    input  logic enable,
    output logic expire
);

    logic [7:0] count;

    // Expiry looks only at the registered count so the caller may fold expiry into clear.
    assign expire = enable && tick && (count == 8'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (tick && count != 8'hFF)
            count <= count + 8'd1;
    end

endmodule

// File: rtl/mode_sequencer.sv
// mode_sequencer: one-hot mode FSM with gated button forwarding and commit strobes.
// Optional inactivity return to CLOCK when MODE_TIMEOUT_EN is defined.
module mode_sequencer
    import clock_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 30
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       TICK_1HZ,
    input  logic       MODE_BTN,
    input  logic [3:0] NUM_SYNC,
    output logic [3:0] MODE,
    output logic [3:0] NUM_OUT,
    output logic       TIME_LOAD,
    output logic       ALARM_LOAD
);

    mode_t      state, next_state;
    logic       dirty, dirty_next, editing, activity, timeout, change;
    logic       time_load_next, alarm_load_next;
    logic [3:0] num_next;

    assign MODE     = state;
    assign editing  = is_edit(state);
    assign activity = MODE_BTN | NUM_SYNC[BTN_UP] | NUM_SYNC[BTN_DOWN] | NUM_SYNC[BTN_RIGHT] | NUM_SYNC[BTN_LEFT];

`ifdef MODE_TIMEOUT_EN
    logic expire;

    idle_timer #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_idle_timer (
        .clk    (CLK),
        .rst    (RESET),
        .clear  (activity | change),
        .tick   (TICK_1HZ),
        .enable (editing),
        .expire (expire)
    );

    assign timeout = expire & ~activity;
`else
    logic unused_tick;
    assign unused_tick = TICK_1HZ | (TIMEOUT_TICKS == 0);
    assign timeout     = 1'b0;
`endif

    always_comb begin
        next_state      = MODE_BTN ? next_mode(state) : timeout ? ST_CLOCK : state;
        change          = next_state != state;
        // Edits coinciding with a mode change are not forwarded, so they do not mark dirty either.
        dirty_next      = change ? 1'b0 : (editing && (NUM_SYNC[BTN_UP] || NUM_SYNC[BTN_DOWN])) ? 1'b1 : dirty;
        time_load_next  = change && dirty && state == ST_TIME_SET;
        alarm_load_next = change && dirty && state == ST_ALARM_SET;
        num_next        = (state != ST_CLOCK && !change) ? NUM_SYNC : 4'b0000;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_CLOCK;
            dirty      <= 1'b0;
            NUM_OUT    <= 4'b0000;
            TIME_LOAD  <= 1'b0;
            ALARM_LOAD <= 1'b0;
        end else begin
            state      <= next_state;
            dirty      <= dirty_next;
            NUM_OUT    <= num_next;
            TIME_LOAD  <= time_load_next;
            ALARM_LOAD <= alarm_load_next;
        end
    end

endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer: directed bench for mode_sequencer with TIMEOUT_TICKS=3.
module tb_mode_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       TICK_1HZ = 1'b0;
    logic       MODE_BTN = 1'b0;
    logic [3:0] NUM_SYNC = 4'b0000;
    logic [3:0] MODE, NUM_OUT;
    logic       TIME_LOAD, ALARM_LOAD;
    int         checks = 0;
    int         errors = 0;

    mode_sequencer #(.TIMEOUT_TICKS(3)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .TICK_1HZ   (TICK_1HZ),
        .MODE_BTN   (MODE_BTN),
        .NUM_SYNC   (NUM_SYNC),
        .MODE       (MODE),
        .NUM_OUT    (NUM_OUT),
        .TIME_LOAD  (TIME_LOAD),
        .ALARM_LOAD (ALARM_LOAD)
    );

    always #5 CLK = ~CLK;

    task automatic cyc(input logic mb, input logic [3:0] ns, input logic tk);
        MODE_BTN = mb;
        NUM_SYNC = ns;
        TICK_1HZ = tk;
        @(posedge CLK);
        #1;
        MODE_BTN = 1'b0;
        NUM_SYNC = 4'b0000;
        TICK_1HZ = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] m, input logic [3:0] n, input logic tl, input logic al);
        chk({tag, ".mode"}, MODE, m);
        chk({tag, ".num"}, NUM_OUT, n);
        chk({tag, ".tload"}, {3'b0, TIME_LOAD}, {3'b0, tl});
        chk({tag, ".aload"}, {3'b0, ALARM_LOAD}, {3'b0, al});
    endtask

    initial begin
        cyc(1'b0, 4'b0000, 1'b0);
        chk_all("reset", 4'b1000, 4'b0000, 1'b0, 1'b0);
        RESET = 1'b0;
        cyc(1'b1, 4'b0000, 1'b0); chk_all("cycle1", 4'b0001, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0); chk_all("cycle2", 4'b0010, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0); chk_all("cycle3", 4'b0100, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0); chk_all("cycle4", 4'b1000, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0011, 1'b0); chk_all("gate_clock", 4'b1000, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0); chk_all("ts_enter", 4'b0001, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0001, 1'b0); chk_all("ts_up", 4'b0001, 4'b0001, 1'b0, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0); chk_all("ts_commit", 4'b0010, 4'b0000, 1'b1, 1'b0);
        cyc(1'b0, 4'b0000, 1'b0); chk_all("ts_commit_once", 4'b0010, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0); chk_all("as_clean_leave", 4'b0100, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0001, 1'b0); chk_all("sw_fwd", 4'b0100, 4'b0001, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b0); chk_all("sw_idle", 4'b0100, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0); chk_all("sw_leave", 4'b1000, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0); chk_all("cur_enter", 4'b0001, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0100, 1'b0); chk_all("cur_press1", 4'b0001, 4'b0100, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b0); chk_all("cur_gap", 4'b0001, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0100, 1'b0); chk_all("cur_press2", 4'b0001, 4'b0100, 1'b0, 1'b0);
        cyc(1'b1, 4'b0100, 1'b0); chk_all("cur_leave", 4'b0010, 4'b0000, 1'b0, 1'b0);
`ifdef MODE_TIMEOUT_EN
        cyc(1'b0, 4'b0001, 1'b0); chk_all("to_up", 4'b0010, 4'b0001, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1); chk_all("to_tick1", 4'b0010, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1); chk_all("to_tick2", 4'b0010, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1); chk_all("to_tick3", 4'b1000, 4'b0000, 1'b0, 1'b1);
        cyc(1'b0, 4'b0000, 1'b0); chk_all("to_after", 4'b1000, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0); chk_all("to_ts", 4'b0001, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0); chk_all("to_as", 4'b0010, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0001, 1'b0); chk_all("act_up", 4'b0010, 4'b0001, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1); chk_all("act_tick1", 4'b0010, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1); chk_all("act_tick2", 4'b0010, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0001, 1'b1); chk_all("act_wins", 4'b0010, 4'b0001, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1); chk_all("act_restart", 4'b0010, 4'b0000, 1'b0, 1'b0);
`else
        cyc(1'b0, 4'b0001, 1'b0); chk_all("noto_up", 4'b0010, 4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 4'b0000, 1'b1);
            chk_all("noto_tick", 4'b0010, 4'b0000, 1'b0, 1'b0);
        end
`endif
        cyc(1'b1, 4'b0000, 1'b0); chk_all("as_commit", 4'b0100, 4'b0000, 1'b0, 1'b1);
        cyc(1'b1, 4'b0000, 1'b0); chk_all("as_to_clock", 4'b1000, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0); chk_all("col_enter", 4'b0001, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0010, 1'b0); chk_all("col_down", 4'b0001, 4'b0010, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1); chk_all("col_tick1", 4'b0001, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1); chk_all("col_tick2", 4'b0001, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0000, 1'b1); chk_all("col_btn_wins", 4'b0010, 4'b0000, 1'b1, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0); chk_all("col_sw", 4'b0100, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0); chk_all("col_clock", 4'b1000, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0); chk_all("rst_enter", 4'b0001, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 4'b0001, 1'b0); chk_all("rst_up", 4'b0001, 4'b0001, 1'b0, 1'b0);
        RESET = 1'b1;
        cyc(1'b0, 4'b0001, 1'b0); chk_all("rst_mid", 4'b1000, 4'b0000, 1'b0, 1'b0);
        RESET = 1'b0;
        cyc(1'b1, 4'b0000, 1'b0); chk_all("rst_ts", 4'b0001, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0); chk_all("rst_discard", 4'b0010, 4'b0000, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
